// File: rtl/serial_sub4_cmp.sv
// Bit-serial a - b - bin, LSB first, one bit per clock.
// Registers diff, borrow and the Gt/Ls/Eq/Error flags once all bits are done.
module serial_sub4_cmp #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             Gt,
  output logic             Ls,
  output logic             Eq,
  output logic             Error
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;

  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             gt_q, gt_d;
  logic             ls_q, ls_d;
  logic             eq_q, eq_d;
  logic             err_q, err_d;

  logic             ai, bi, di, br_nx;
  logic [WIDTH-1:0] shifted;
  logic             last;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    gt_d    = gt_q;
    ls_d    = ls_q;
    eq_d    = eq_q;
    err_d   = err_q;

    ai      = a_q[0];
    bi      = b_q[0];
    di      = ai ^ bi ^ br_q;
    br_nx   = (~ai & bi) | (~(ai ^ bi) & br_q);
    shifted = {di, res_q[WIDTH-1:1]};
    last    = (cnt_q == CW'(WIDTH - 1));

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nx;
        res_d = shifted;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          // br_q here is the borrow entering the MSB
          state_d = DONE;
          diff_d  = shifted;
          bout_d  = br_nx;
          ls_d    = br_nx;
          eq_d    = (shifted == '0) & ~br_nx;
          gt_d    = (shifted != '0) & ~br_nx;
          err_d   = br_q ^ br_nx;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      gt_q    <= 1'b0;
      ls_q    <= 1'b0;
      eq_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      gt_q    <= gt_d;
      ls_q    <= ls_d;
      eq_q    <= eq_d;
      err_q   <= err_d;
    end
  end

  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign bout  = bout_q;
  assign Gt    = gt_q;
  assign Ls    = ls_q;
  assign Eq    = eq_q;
  assign Error = err_q;

endmodule

// File: tb/tb_serial_sub4_cmp.sv
// Bench for serial_sub4_cmp: vector table, scoreboard queue,
// plus hand sequences for busy-start, mid-op reset and back-to-back.
module tb_serial_sub4_cmp;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout, Gt, Ls, Eq, Error;
  logic [W-1:0] diff;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         gt;
    logic         ls;
    logic         eq;
    logic         err;
  } vec_t;

  vec_t vecs[11];
  vec_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  serial_sub4_cmp #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout),
    .Gt(Gt), .Ls(Ls), .Eq(Eq), .Error(Error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every done pulse pops one expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      vec_t e;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: got diff=%b with empty queue", diff);
      end else begin
        e = sb.pop_front();
        if ({diff, bout, Gt, Ls, Eq, Error} !==
            {e.diff, e.bout, e.gt, e.ls, e.eq, e.err}) begin
          n_bad++;
          $display("FAIL result a=%b b=%b bin=%b: got diff=%b bo=%b gt=%b ls=%b eq=%b er=%b expected diff=%b bo=%b gt=%b ls=%b eq=%b er=%b",
                   e.a, e.b, e.bin, diff, bout, Gt, Ls, Eq, Error,
                   e.diff, e.bout, e.gt, e.ls, e.eq, e.err);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(n < 20), 1);
  endtask

  // one operation; optionally pokes start while busy
  task automatic do_op(input vec_t v, input bit poke);
    int cyc = 0;
    int bcnt = 0;
    wait_idle();
    a = v.a; b = v.b; bin = v.bin; start = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      if (cyc == 0) begin
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      end
      if (poke && cyc == 1) start = 1'b1;
      if (poke && cyc == 2) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, W);
    check("busy_cycles", bcnt, W);
  endtask

  function automatic vec_t mk(input logic [W-1:0] a_, b_, input logic bin_,
                              input logic [W-1:0] d_, input logic bo_, gt_,
                              ls_, eq_, er_);
    vec_t v;
    v.a = a_; v.b = b_; v.bin = bin_; v.diff = d_; v.bout = bo_;
    v.gt = gt_; v.ls = ls_; v.eq = eq_; v.err = er_;
    return v;
  endfunction

  initial begin
    int dcyc[3];
    int nd;
    vec_t held;
    vecs[0]  = mk(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 1, 0);
    vecs[1]  = mk(4'b0110, 4'b1000, 0, 4'b1110, 1, 0, 1, 0, 1);
    vecs[2]  = mk(4'b1000, 4'b0101, 0, 4'b0011, 0, 1, 0, 0, 1);
    vecs[3]  = mk(4'b0000, 4'b1111, 1, 4'b0000, 1, 0, 1, 0, 0);
    vecs[4]  = mk(4'b0000, 4'b0001, 0, 4'b1111, 1, 0, 1, 0, 0);
    vecs[5]  = mk(4'b0111, 4'b1111, 0, 4'b1000, 1, 0, 1, 0, 1);
    vecs[6]  = mk(4'b1111, 4'b0000, 1, 4'b1110, 0, 1, 0, 0, 0);
    vecs[7]  = mk(4'b0101, 4'b0101, 1, 4'b1111, 1, 0, 1, 0, 0);
    vecs[8]  = mk(4'b1001, 4'b0011, 0, 4'b0110, 0, 1, 0, 0, 1);
    vecs[9]  = mk(4'b1100, 4'b0100, 1, 4'b0111, 0, 1, 0, 0, 1);
    vecs[10] = mk(4'b0011, 4'b0010, 1, 4'b0000, 0, 0, 0, 1, 0);

    #12;
    check("rst_outputs", int'({busy, done, diff, bout, Gt, Ls, Eq, Error}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) do_op(vecs[i], i == 3);

    // result must hold after done while start is poked with new operands
    @(negedge clk);
    held = vecs[10];
    a = 4'b1010; b = 4'b0001; start = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_diff", int'(diff), int'(held.diff));
    check("hold_eq", int'(Eq), int'(held.eq));

    // abort with reset after two SHIFT cycles
    wait_idle();
    a = 4'b0111; b = 4'b0001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_outputs",
          int'({busy, done, diff, bout, Gt, Ls, Eq, Error}), 0);
    repeat (3) @(negedge clk);
    check("abort_no_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", int'({busy, done}), 0);
    do_op(mk(4'b0111, 4'b0001, 0, 4'b0110, 0, 1, 0, 0, 0), 1'b0);

    // back-to-back with start held high
    wait_idle();
    a = 4'b0101; b = 4'b0101; bin = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++)
      sb.push_back(mk(4'b0101, 4'b0101, 0, 4'b0000, 0, 0, 0, 1, 0));
    nd = 0;
    for (int k = 0; k < 40 && nd < 3; k++) begin
      @(posedge clk); #1;
      if (done) begin
        dcyc[nd] = k;
        nd++;
        if (nd == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", nd, 3);
    if (nd == 3) begin
      check("b2b_first", dcyc[0], W);
      check("b2b_gap1", dcyc[1] - dcyc[0], W + 2);
      check("b2b_gap2", dcyc[2] - dcyc[1], W + 2);
    end
    repeat (10) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
